csa_stream_accumulator: RTL

//  Multi-operand carry-save accumulator. It sums a stream of WIDTH-bit unsigned operands
//  by keeping a redundant sum/carry pair, so there is no carry-propagate chain per beat.

---
 rtl/csa_stream_accumulator_if.sv | 35 +++
 rtl/csa_stream_accumulator.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/csa_stream_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : csa_stream_accumulator_if
//  Description : Operand stream in, resolved-sum stream out, for the
//                carry-save stream accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
interface csa_stream_accumulator_if #(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 16
);
  localparam int CNT_W = $clog2(MAX_OPS) + 1;
  localparam int ACC_W = WIDTH + $clog2(MAX_OPS);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : csa_stream_accumulator
//  Description : Multi-operand carry-save accumulator; one carry-propagate
//                add per group, result offered on a valid/ready output.
//  Revision    : 1.0  initial release
// ============================================================================
module csa_stream_accumulator #(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 16
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  csa_stream_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_OPS) + 1;
  localparam int ACC_W = WIDTH + $clog2(MAX_OPS);
  localparam int PAD_W = ACC_W - WIDTH;
  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_OPS);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_RES = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [ACC_W-1:0] r_s;
  logic [ACC_W-1:0] r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] w_s_nxt;
  logic [ACC_W-1:0] w_c_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;
  logic             w_out_valid_nxt;
  logic [ACC_W-1:0] w_out_sum_nxt;
  logic [CNT_W-1:0] w_out_count_nxt;
  logic             w_out_ovf_nxt;

  logic [ACC_W-1:0] w_x;
  logic [ACC_W-1:0] w_csa_s;
  logic [ACC_W-1:0] w_csa_c;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_full;

  // 3:2 compression of the redundant pair with the new operand; the carry
  // word shifts up one place and its top bit falls off (sum never needs it).
  assign w_x      = {{PAD_W{1'b0}}, bus.in_data};
  assign w_csa_s  = r_s ^ r_c ^ w_x;
  assign w_csa_c  = ((r_s & r_c) | (r_s & w_x) | (r_c & w_x)) << 1;

  assign w_in_ready = (r_state == ST_ACC);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_full     = (r_cnt == c_max_cnt);

  always_comb begin
    w_state_nxt     = r_state;
    w_s_nxt         = r_s;
    w_c_nxt         = r_c;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;
    w_out_sum_nxt   = r_out_sum;
    w_out_count_nxt = r_out_count;
    w_out_ovf_nxt   = r_out_ovf;

    case (r_state)
      ST_ACC: begin
        if (w_accept) begin
          if (w_full) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_s_nxt   = w_csa_s;
            w_c_nxt   = w_csa_c;
            w_cnt_nxt = r_cnt + c_one;
          end
          // A dropped beat still closes the group when it carries last.
          if (bus.in_last) begin
            w_state_nxt = ST_RES;
          end
        end
      end

      ST_RES: begin
        w_out_sum_nxt   = r_s + r_c;
        w_out_count_nxt = r_cnt;
        w_out_ovf_nxt   = r_ovf;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = ST_OUT;
      end

      ST_OUT: begin
        if (r_out_valid && bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_s_nxt         = '0;
          w_c_nxt         = '0;
          w_cnt_nxt       = '0;
          w_ovf_nxt       = 1'b0;
          w_state_nxt     = ST_ACC;
        end
      end

      default: begin
        w_state_nxt = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_s         <= '0;
      r_c         <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_s         <= w_s_nxt;
      r_c         <= w_c_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_sum   <= w_out_sum_nxt;
      r_out_count <= w_out_count_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
